// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle shared by the arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16
);
  import fifo_arb_pkg::*;

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic [IDX_W-1:0]              src_id;
  logic                          full;
  logic                          almostfull;
  logic                          wr_ack;
  logic                          overflow;

  modport master (
    input  req, req_data, full, almostfull, wr_ack, overflow,
    output gnt, wr_en, data_in, src_id
  );

  modport slave (
    output req, req_data, full, almostfull, wr_ack, overflow,
    input  gnt, wr_en, data_in, src_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos     = (32'(ptr) + k) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (en && !found && req[pos_idx]) begin
        found        = 1'b1;
        gnt[pos_idx] = 1'b1;
        idx          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with full/almostfull throttling, write-ack checking and a sticky-error halt.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr_err,
  fifo_wr_arbiter_if.master   bus,
  output logic                ack_err,
  output logic                ovf_err,
  output logic                halted
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || FIFO_DEPTH < 2) begin : g_cfg_check
    $error("fifo_wr_arbiter: unsupported NUM_REQ/FIFO_DEPTH");
  end

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      src_id_q, src_id_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  pend_q, pend_d;
  logic                  wr_en_q, wr_en_d;
  logic                  ack_err_q, ack_err_d;
  logic                  ovf_err_q, ovf_err_d;

  logic                  can_wr_c;
  logic                  ack_miss_c;
  logic                  err_c;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [IDX_W-1:0]      pick_idx_c;
  logic [FIFO_WIDTH-1:0] sel_data_c;

  // The write landing at this edge is counted so almostfull alone is enough headroom.
  assign can_wr_c = (state_q == RUN) && en && !bus.full && !(wr_en_q && bus.almostfull);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .en  (can_wr_c),
    .gnt (gnt_c),
    .idx (pick_idx_c)
  );

  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx_c == IDX_W'(k)) sel_data_c = bus.req_data[k*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_id_d   = src_id_q;
    data_d     = data_q;
    pend_d     = wr_en_q;
    wr_en_d    = 1'b0;
    ack_miss_c = pend_q && !bus.wr_ack;
    err_c      = ack_miss_c || bus.overflow;
    ack_err_d  = ack_miss_c   || (ack_err_q && !clr_err);
    ovf_err_d  = bus.overflow || (ovf_err_q && !clr_err);

    if (|gnt_c) begin
      wr_en_d  = 1'b1;
      data_d   = sel_data_c;
      src_id_d = pick_idx_c;
      rr_ptr_d = (pick_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
    end

    unique case (state_q)
      IDLE:    if (en)      state_d = RUN;
      RUN:     if (!en)     state_d = IDLE;
      HALT:    if (clr_err) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
    // A fresh error beats a simultaneous clear.
    if (err_c) state_d = HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      src_id_q  <= '0;
      data_q    <= '0;
      pend_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      ack_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      src_id_q  <= src_id_d;
      data_q    <= data_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      ack_err_q <= ack_err_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.wr_en   = wr_en_q;
  assign bus.data_in = data_q;
  assign bus.src_id  = src_id_q;
  assign ack_err     = ack_err_q;
  assign ovf_err     = ovf_err_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a behavioural model plus a FIFO stand-in.
module tb_fifo_wr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst, en, clr_err;
  logic ack_err, ovf_err, halted;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr_err (clr_err),
    .bus     (bus),
    .ack_err (ack_err),
    .ovf_err (ovf_err),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  // FIFO stand-in and stimulus knobs
  int f_cnt;
  bit f_ovf, ack_next, drain, suppress, force_ovf, armed;

  // Behavioural model: 0 idle, 1 run, 2 halt
  int          m_st, m_ptr, m_src;
  bit          m_pend, m_wr, m_ack_err, m_ovf_err;
  logic [W-1:0] m_data;

  int n_vec, n_err;
  int src_log[$];
  logic [N-1:0] last_gnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winner for this cycle, or -1 when nothing may be granted.
  function automatic int model_pick();
    int r;
    if (!(m_st == 1 && en && !bus.full && !(m_wr && bus.almostfull))) return -1;
    r = int'(bus.req);
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (m_ptr + k) % int'(N);
      if (((r >> j) & 1) == 1) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input int w);
    bit miss, ovf;
    if (rst) begin
      m_st = 0; m_ptr = 0; m_src = 0; m_pend = 0; m_wr = 0;
      m_ack_err = 0; m_ovf_err = 0; m_data = '0;
      return;
    end
    miss = m_pend && !bus.wr_ack;
    ovf  = bus.overflow;
    m_ack_err = miss || (m_ack_err && !clr_err);
    m_ovf_err = ovf  || (m_ovf_err && !clr_err);
    m_pend = m_wr;
    m_wr   = (w >= 0);
    if (w >= 0) begin
      m_data = bus.req_data[w*W +: W];
      m_src  = w;
      m_ptr  = (w + 1) % int'(N);
    end
    if (miss || ovf)              m_st = 2;
    else if (m_st == 0 && en)     m_st = 1;
    else if (m_st == 1 && !en)    m_st = 0;
    else if (m_st == 2 && clr_err) m_st = 0;
  endtask

  task automatic cycle();
    int w;
    logic [N-1:0] exp_gnt;
    bus.req_data   = {$urandom, $urandom};
    bus.full       = (f_cnt >= int'(DEPTH));
    bus.almostfull = (f_cnt == int'(DEPTH) - 1);
    bus.overflow   = f_ovf | force_ovf;
    bus.wr_ack     = ack_next;
    #1;
    w = model_pick();
    exp_gnt = (w < 0) ? '0 : N'(1) << w;
    last_gnt = bus.gnt;
    if (armed) check_val("gnt", bus.gnt, exp_gnt);
    model_edge(w);
    ack_next = bus.wr_en && !suppress;
    if (drain && f_cnt > 0) f_cnt--;
    if (bus.wr_en === 1'b1) begin
      if (f_cnt >= int'(DEPTH)) f_ovf = 1'b1;
      else f_cnt++;
    end
    @(posedge clk);
    armed = 1'b1;
    @(negedge clk);
    check_val("wr_en",   bus.wr_en,   m_wr);
    check_val("data_in", bus.data_in, m_data);
    check_val("src_id",  bus.src_id,  m_src);
    check_val("ack_err", ack_err,     m_ack_err);
    check_val("ovf_err", ovf_err,     m_ovf_err);
    check_val("halted",  halted,      m_st == 2);
    if (bus.wr_en === 1'b1) src_log.push_back(int'(bus.src_id));
  endtask

  task automatic reset_all();
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; bus.req = '0;
    suppress = 1'b0; force_ovf = 1'b0;
    repeat (2) cycle();
    rst = 1'b0; f_cnt = 0; ack_next = 1'b0; f_ovf = 1'b0;
    src_log.delete();
  endtask

  initial begin
    int exp_seq[6];
    n_vec = 0; n_err = 0; f_cnt = 0; f_ovf = 0; ack_next = 0;
    drain = 0; suppress = 0; force_ovf = 0; armed = 0;
    m_st = 0; m_ptr = 0; m_src = 0; m_pend = 0; m_wr = 0;
    m_ack_err = 0; m_ovf_err = 0; m_data = '0;
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; bus.req = '0;

    // Single requester into an undrained FIFO: throttle must stop at exactly DEPTH writes
    reset_all();
    check_val("rst_wr_en", bus.wr_en, 0);
    check_val("rst_halted", halted, 0);
    en = 1'b1; bus.req = 4'b0100;
    repeat (20) cycle();
    check_val("t1_writes", src_log.size(), DEPTH);
    foreach (src_log[i]) check_val("t1_src", src_log[i], 2);
    check_val("t1_fill", f_cnt, DEPTH);
    check_val("t1_fifo_ovf", f_ovf, 0);
    check_val("t1_ack_err", ack_err, 0);

    // All requesting, FIFO drained: strict rotation
    drain = 1'b1;
    reset_all();
    en = 1'b1; bus.req = 4'b1111;
    repeat (8) cycle();
    exp_seq = '{0, 1, 2, 3, 0, 1};
    check_val("t2_count", src_log.size() >= 6, 1);
    for (int i = 0; i < 6 && i < src_log.size(); i++) check_val("t2_seq", src_log[i], exp_seq[i]);

    // Pointer after a grant to 1 starts the search at 2
    reset_all();
    en = 1'b1; bus.req = '0; cycle();
    bus.req = 4'b0010; cycle();
    bus.req = 4'b1010; cycle(); cycle();
    bus.req = '0; cycle();
    check_val("t3_count", src_log.size(), 3);
    if (src_log.size() == 3) begin
      check_val("t3_first", src_log[0], 1);
      check_val("t3_second", src_log[1], 3);
      check_val("t3_third", src_log[2], 1);
    end

    // Missing ack halts; clr_err recovers
    reset_all();
    en = 1'b1; bus.req = 4'b0001;
    repeat (3) cycle();
    suppress = 1'b1; cycle(); suppress = 1'b0;
    repeat (3) cycle();
    check_val("t4_halted", halted, 1);
    check_val("t4_ack_err", ack_err, 1);
    check_val("t4_gnt", last_gnt, 0);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    check_val("t4_clr_halted", halted, 0);
    check_val("t4_clr_ack_err", ack_err, 0);
    src_log.delete();
    repeat (3) cycle();
    check_val("t4_resumed", src_log.size() > 0, 1);

    // Reset while a write is on the port
    reset_all();
    en = 1'b1; bus.req = 4'b0001;
    repeat (3) cycle();
    check_val("t5_pre_wr", bus.wr_en, 1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_val("t5_wr_en", bus.wr_en, 0);
    check_val("t5_src", bus.src_id, 0);
    check_val("t5_data", bus.data_in, 0);
    bus.req = 4'b1111; src_log.delete();
    repeat (3) cycle();
    check_val("t5_restart", (src_log.size() > 0) ? src_log[0] : -1, 0);
    check_val("t5_ack_err", ack_err, 0);

    // en dropped with a write in flight
    reset_all();
    en = 1'b1; bus.req = 4'b0001;
    repeat (3) cycle();
    en = 1'b0; cycle();
    check_val("t6_gnt", last_gnt, 0);
    repeat (2) cycle();
    check_val("t6_ack_err", ack_err, 0);
    check_val("t6_halted", halted, 0);

    // Randomized traffic
    reset_all();
    for (int c = 0; c < 400; c++) begin
      bus.req   = N'($urandom_range(0, 15));
      en        = ($urandom_range(0, 9) != 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      drain     = ($urandom_range(0, 1) == 1);
      suppress  = ($urandom_range(0, 29) == 0);
      force_ovf = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; force_ovf = 1'b0; suppress = 1'b0;
    check_val("rand_fifo_ovf", f_ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
